// File: rtl/msi_pkg.sv
// Shared MSI definitions: block state encodings and the bus-message bundle
// raised by the CPU-side controller.
package msi_pkg;

  typedef enum logic [1:0] {
    StInvalid  = 2'b00,
    StShared   = 2'b01,
    StModified = 2'b10
  } msi_state_e;

  typedef struct packed {
    logic read_miss;
    logic write_miss;
    logic invalidate;
    logic write_back;
  } msi_msg_t;

  localparam msi_msg_t MsgNone = '0;

endpackage

// File: rtl/msi_cache_block_if.sv
// CPU request / block status / bus-message bundle for one MSI cache block.
interface msi_cache_block_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4
) ();

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] fill_data;
  logic [1:0]        blk_state;
  logic [ADDR_W-1:0] blk_addr;
  logic [DATA_W-1:0] blk_data;
  logic              hit;
  logic              read_miss;
  logic              write_miss;
  logic              invalidate;
  logic              write_back;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, fill_data,
    input  blk_state, blk_addr, blk_data, hit,
    input  read_miss, write_miss, invalidate, write_back, wb_addr, wb_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, fill_data,
    output blk_state, blk_addr, blk_data, hit,
    output read_miss, write_miss, invalidate, write_back, wb_addr, wb_data
  );

endinterface

// File: rtl/msi_cpu_fsm.sv
// Combinational MSI next-state and bus-message decode for CPU requests,
// evaluated against the registered block state and tag.
module msi_cpu_fsm
  import msi_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4
) (
  input  msi_state_e        state_i,
  input  logic [ADDR_W-1:0] tag_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output msi_state_e        state_d_o,
  output logic [ADDR_W-1:0] tag_d_o,
  output logic [DATA_W-1:0] data_d_o,
  output msi_msg_t          msg_o,
  output logic              hit_o
);

  logic valid_state;

  assign valid_state = (state_i == StShared) || (state_i == StModified);
  assign hit_o       = valid_state && (req_addr_i == tag_i);

  always_comb begin
    state_d_o = state_i;
    tag_d_o   = tag_i;
    data_d_o  = data_i;
    msg_o     = MsgNone;
    case (state_i)
      StInvalid: begin
        if (req_valid_i) begin
          tag_d_o = req_addr_i;
          if (req_write_i) begin
            state_d_o        = StModified;
            data_d_o         = req_data_i;
            msg_o.write_miss = 1'b1;
          end else begin
            state_d_o       = StShared;
            data_d_o        = fill_data_i;
            msg_o.read_miss = 1'b1;
          end
        end
      end
      StShared: begin
        if (req_valid_i) begin
          if (req_write_i) begin
            state_d_o = StModified;
            data_d_o  = req_data_i;
            if (hit_o) begin
              msg_o.invalidate = 1'b1;
            end else begin
              tag_d_o          = req_addr_i;
              msg_o.write_miss = 1'b1;
            end
          end else if (!hit_o) begin
            // Clean copy: replace silently, nothing to write back.
            tag_d_o         = req_addr_i;
            data_d_o        = fill_data_i;
            msg_o.read_miss = 1'b1;
          end
        end
      end
      StModified: begin
        if (req_valid_i) begin
          if (hit_o) begin
            if (req_write_i) data_d_o = req_data_i;
          end else begin
            tag_d_o          = req_addr_i;
            msg_o.write_back = 1'b1;
            if (req_write_i) begin
              data_d_o         = req_data_i;
              msg_o.write_miss = 1'b1;
            end else begin
              state_d_o       = StShared;
              data_d_o        = fill_data_i;
              msg_o.read_miss = 1'b1;
            end
          end
        end
      end
      // Corrupted encoding: behave as Invalid, drop the request, recover.
      default: state_d_o = StInvalid;
    endcase
  end

endmodule

// File: rtl/msi_cache_block.sv
// Single-line MSI cache block: holds state/tag/data and registers the bus
// messages produced by msi_cpu_fsm for exactly one cycle.
module msi_cache_block
  import msi_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4
) (
  input logic               clock,
  input logic               resetn,
  msi_cache_block_if.slave  bus
);

  msi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  msi_msg_t          msg_q, msg_d;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              hit;

  msi_cpu_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cpu_fsm (
    .state_i     (state_q),
    .tag_i       (tag_q),
    .data_i      (data_q),
    .req_valid_i (bus.req_valid),
    .req_write_i (bus.req_write),
    .req_addr_i  (bus.req_addr),
    .req_data_i  (bus.req_data),
    .fill_data_i (bus.fill_data),
    .state_d_o   (state_d),
    .tag_d_o     (tag_d),
    .data_d_o    (data_d),
    .msg_o       (msg_d),
    .hit_o       (hit)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StInvalid;
      tag_q     <= '0;
      data_q    <= '0;
      msg_q     <= MsgNone;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      msg_q   <= msg_d;
      // Capture the victim before it is overwritten in this same edge.
      if (msg_d.write_back) begin
        wb_addr_q <= tag_q;
        wb_data_q <= data_q;
      end
    end
  end

  assign bus.blk_state  = state_q;
  assign bus.blk_addr   = tag_q;
  assign bus.blk_data   = data_q;
  assign bus.hit        = hit;
  assign bus.read_miss  = msg_q.read_miss;
  assign bus.write_miss = msg_q.write_miss;
  assign bus.invalidate = msg_q.invalidate;
  assign bus.write_back = msg_q.write_back;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_msi_cache_block.sv
// Directed + random bench for msi_cache_block: a small MSI reference model
// pushes expected block/pulse values that are popped after each edge.
module tb_msi_cache_block;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 4;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  msi_cache_block_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  msi_cache_block #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string          name;
    logic [1:0]     state;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic           rm;
    logic           wm;
    logic           inv;
    logic           wb;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0]    m_state;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'b00;
    m_addr  = '0;
    m_data  = '0;
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".state"}, bus.blk_state, 2'b00);
    check({name, ".addr"}, bus.blk_addr, 0);
    check({name, ".data"}, bus.blk_data, 0);
    check({name, ".pulses"}, {bus.read_miss, bus.write_miss, bus.invalidate, bus.write_back}, 0);
    check({name, ".wb_addr"}, bus.wb_addr, 0);
    check({name, ".wb_data"}, bus.wb_data, 0);
  endtask

  task automatic compare();
    exp_t e;
    check("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.name, ".state"}, bus.blk_state, e.state);
      check({e.name, ".addr"}, bus.blk_addr, e.addr);
      check({e.name, ".data"}, bus.blk_data, e.data);
      check({e.name, ".read_miss"}, bus.read_miss, e.rm);
      check({e.name, ".write_miss"}, bus.write_miss, e.wm);
      check({e.name, ".invalidate"}, bus.invalidate, e.inv);
      check({e.name, ".write_back"}, bus.write_back, e.wb);
      if (e.wb) begin
        check({e.name, ".wb_addr"}, bus.wb_addr, e.wb_addr);
        check({e.name, ".wb_data"}, bus.wb_data, e.wb_data);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, predict, then check after the edge.
  task automatic drive(input string name, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] f);
    exp_t e;
    logic hit_m;
    @(negedge clock);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.fill_data = f;
    hit_m = (m_state != 2'b00) && (a == m_addr);
    #1;
    check({name, ".hit"}, bus.hit, hit_m);
    e.name    = name;
    e.state   = m_state;
    e.addr    = m_addr;
    e.data    = m_data;
    e.rm      = 1'b0;
    e.wm      = 1'b0;
    e.inv     = 1'b0;
    e.wb      = 1'b0;
    e.wb_addr = m_addr;
    e.wb_data = m_data;
    if (v) begin
      if (!w) begin
        if (!hit_m) begin
          e.rm    = 1'b1;
          e.wb    = (m_state == 2'b10);
          e.state = 2'b01;
          e.addr  = a;
          e.data  = f;
        end
      end else begin
        e.state = 2'b10;
        e.data  = d;
        if (hit_m) begin
          e.inv = (m_state == 2'b01);
        end else begin
          e.wm   = 1'b1;
          e.wb   = (m_state == 2'b10);
          e.addr = a;
        end
      end
    end
    m_state = e.state;
    m_addr  = e.addr;
    m_data  = e.data;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Request held valid while in reset must be discarded.
    resetn        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 3'b111;
    bus.req_data  = 4'hF;
    bus.fill_data = 4'h0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    check("reset.hit", bus.hit, 0);
    @(posedge clock);
    #2;
    resetn        = 1'b1;
    bus.req_valid = 1'b0;

    drive("r036", 1, 0, 3'b010, 4'h0, 4'hA);
    check("r036.state_c", bus.blk_state, 2'b01);
    check("r036.addr_c", bus.blk_addr, 3'b010);
    check("r036.data_c", bus.blk_data, 4'hA);
    check("r036.rm_c", bus.read_miss, 1);
    drive("r036_idle", 0, 0, 3'b010, 4'h0, 4'h0);
    check("r036.rm_drop", bus.read_miss, 0);

    drive("r037", 1, 1, 3'b010, 4'h5, 4'h0);
    check("r037.state_c", bus.blk_state, 2'b10);
    check("r037.data_c", bus.blk_data, 4'h5);
    check("r037.msgs_c", {bus.invalidate, bus.read_miss, bus.write_miss}, 3'b100);

    drive("r038", 1, 0, 3'b100, 4'h0, 4'h3);
    check("r038.wb_rm_c", {bus.write_back, bus.read_miss}, 2'b11);
    check("r038.wb_addr_c", bus.wb_addr, 3'b010);
    check("r038.wb_data_c", bus.wb_data, 4'h5);
    check("r038.blk_c", {bus.blk_state, bus.blk_addr, bus.blk_data}, {2'b01, 3'b100, 4'h3});

    drive("s_wr_miss", 1, 1, 3'b010, 4'h5, 4'h0);
    drive("r039", 1, 1, 3'b110, 4'hC, 4'h0);
    check("r039.wb_wm_c", {bus.write_back, bus.write_miss}, 2'b11);
    check("r039.wb_c", {bus.wb_addr, bus.wb_data}, {3'b010, 4'h5});
    check("r039.blk_c", {bus.blk_state, bus.blk_addr, bus.blk_data}, {2'b10, 3'b110, 4'hC});

    drive("m_wr_hit", 1, 1, 3'b110, 4'h7, 4'h0);
    drive("m_rd_hit", 1, 0, 3'b110, 4'h0, 4'hF);
    drive("m_rd_miss", 1, 0, 3'b100, 4'h0, 4'h9);
    drive("s_rd_miss", 1, 0, 3'b011, 4'h0, 4'h2);
    drive("s_wr_miss2", 1, 1, 3'b101, 4'hE, 4'h0);
    drive("m_rd_miss2", 1, 0, 3'b100, 4'h0, 4'h4);
    drive("r040_hit", 1, 0, 3'b100, 4'h0, 4'hB);
    for (int i = 0; i < 3; i++) drive("r040_idle", 0, 1, 3'b001, 4'hF, 4'hF);
    check("r040.blk_c", {bus.blk_state, bus.blk_addr, bus.blk_data}, {2'b01, 3'b100, 4'h4});

    // Asynchronous reset between edges while a pulse is visible.
    drive("pre_rst", 1, 1, 3'b001, 4'h6, 4'h0);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_outputs("r041");
    model_reset();
    @(posedge clock);
    #2;
    resetn = 1'b1;

    drive("inv_wr", 1, 1, 3'b001, 4'h6, 4'h0);

    for (int i = 0; i < 40; i++) begin
      drive("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 3)), DW'($urandom), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
